// File: rtl/ddr3_test_pkg.sv
// Shared types and default geometry for the DDR3 write-side scheduler.
// Provides the scheduler FSM encoding and default widths/frame layout.
package ddr3_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } wr_state_t;

  localparam int DEF_DATA_W      = 64;
  localparam int DEF_ADDR_W      = 25;
  localparam int DEF_BURST_LEN   = 32;
  localparam int DEF_FRAME_WORDS = 777600;
  localparam int DEF_FRAME_BASE0 = 0;
  localparam int DEF_FRAME_BASE1 = 1048576;

endpackage

// File: rtl/ddr3_wr_sched_cnt.sv
// ddr3_burst_cnt: loadable down-counter with a terminal (cnt==1) flag.
// Ports: clk, rst (async high), load/load_val, dec; outputs cnt, last.
module ddr3_burst_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/ddr3_wr_sched.sv
// ddr3_wr_sched: drains the show-ahead frame FIFO into DDR3 as fixed bursts,
// ping-ponging between two frame buffers. Ports: FIFO read side
// (fifo_usedw/fifo_q/fifo_rdreq), Avalon-MM write side (avl_*), frame status.
module ddr3_wr_sched
  import ddr3_test_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int SIZE_W      = 6,
  parameter int USEDW_W     = 8,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int FRAME_BASE0 = DEF_FRAME_BASE0,
  parameter int FRAME_BASE1 = DEF_FRAME_BASE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               local_init_done,
  input  logic               frame_start,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [DATA_W-1:0]  fifo_q,
  output logic               fifo_rdreq,
  input  logic               avl_ready,
  output logic               avl_write_req,
  output logic               avl_burstbegin,
  output logic [ADDR_W-1:0]  avl_addr,
  output logic [SIZE_W-1:0]  avl_size,
  output logic [DATA_W-1:0]  avl_wdata,
  output logic               frame_done,
  output logic               buf_sel,
  output logic               abort_err
);

  localparam int WL_W = $clog2(FRAME_WORDS + 1);

  wr_state_t state, state_n;

  logic              wr_buf, wr_buf_n;
  logic [ADDR_W-1:0] cur_addr, cur_addr_n;
  logic              abort_pend, abort_pend_n;
  logic              abort_err_n, write_req_n, burstbegin_n;
  logic              frame_done_n, buf_sel_n;
  logic [ADDR_W-1:0] addr_n;
  logic [SIZE_W-1:0] size_n;

  logic              beat_load, words_load;
  logic [SIZE_W-1:0] beat_cnt, burst_n;
  logic [WL_W-1:0]   words_left;
  logic              beat_last, words_last;
  logic              acc, first_beat, frame_end, fs_abort;

  function automatic logic [ADDR_W-1:0] base_of(input logic b);
    return b ? ADDR_W'(FRAME_BASE1) : ADDR_W'(FRAME_BASE0);
  endfunction

  assign acc        = avl_write_req & avl_ready;
  assign first_beat = (beat_cnt == avl_size);
  // A pulse coinciding with the final beat of a frame is not an abort.
  assign frame_end  = (state == BURST) & acc & beat_last & words_last;
  assign fs_abort   = frame_start & ~frame_end;

  always_comb begin
    if (words_left < WL_W'(BURST_LEN)) begin
      burst_n = words_left[SIZE_W-1:0];
    end else begin
      burst_n = SIZE_W'(BURST_LEN);
    end
  end

  ddr3_burst_cnt #(.W(SIZE_W)) u_beat (
    .clk      (clk),
    .rst      (rst),
    .load     (beat_load),
    .load_val (burst_n),
    .dec      (acc),
    .cnt      (beat_cnt),
    .last     (beat_last)
  );

  ddr3_burst_cnt #(.W(WL_W)) u_words (
    .clk      (clk),
    .rst      (rst),
    .load     (words_load),
    .load_val (WL_W'(FRAME_WORDS)),
    .dec      (acc),
    .cnt      (words_left),
    .last     (words_last)
  );

  always_comb begin
    state_n      = state;
    wr_buf_n     = wr_buf;
    cur_addr_n   = cur_addr;
    abort_pend_n = abort_pend;
    abort_err_n  = abort_err;
    write_req_n  = avl_write_req;
    burstbegin_n = avl_burstbegin;
    addr_n       = avl_addr;
    size_n       = avl_size;
    frame_done_n = 1'b0;
    buf_sel_n    = buf_sel;
    beat_load    = 1'b0;
    words_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (local_init_done && frame_start) begin
          cur_addr_n = base_of(wr_buf);
          words_load = 1'b1;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (frame_start) begin
          abort_err_n  = 1'b1;
          abort_pend_n = 1'b0;
          cur_addr_n   = base_of(wr_buf);
          words_load   = 1'b1;
        end else if (32'(fifo_usedw) >= 32'(burst_n)) begin
          write_req_n  = 1'b1;
          burstbegin_n = 1'b1;
          addr_n       = cur_addr;
          size_n       = burst_n;
          beat_load    = 1'b1;
          state_n      = BURST;
        end
      end
      BURST: begin
        if (fs_abort) begin
          abort_err_n  = 1'b1;
          abort_pend_n = 1'b1;
        end
        // Still on the first beat until the counter leaves its load value.
        burstbegin_n = first_beat & ~acc;
        if (acc && beat_last) begin
          write_req_n = 1'b0;
          cur_addr_n  = cur_addr + ADDR_W'(avl_size);
          if (abort_pend || fs_abort) begin
            cur_addr_n   = base_of(wr_buf);
            words_load   = 1'b1;
            abort_pend_n = 1'b0;
            state_n      = WAIT;
          end else if (words_last) begin
            frame_done_n = 1'b1;
            buf_sel_n    = wr_buf;
            wr_buf_n     = ~wr_buf;
            state_n      = DONE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_buf         <= 1'b0;
      cur_addr       <= '0;
      abort_pend     <= 1'b0;
      abort_err      <= 1'b0;
      avl_write_req  <= 1'b0;
      avl_burstbegin <= 1'b0;
      avl_addr       <= '0;
      avl_size       <= '0;
      frame_done     <= 1'b0;
      buf_sel        <= 1'b0;
    end else begin
      state          <= state_n;
      wr_buf         <= wr_buf_n;
      cur_addr       <= cur_addr_n;
      abort_pend     <= abort_pend_n;
      abort_err      <= abort_err_n;
      avl_write_req  <= write_req_n;
      avl_burstbegin <= burstbegin_n;
      avl_addr       <= addr_n;
      avl_size       <= size_n;
      frame_done     <= frame_done_n;
      buf_sel        <= buf_sel_n;
    end
  end

  // Beats of an aborted burst still go out, but carry zeros and pop nothing.
  assign fifo_rdreq = avl_write_req & avl_ready & ~abort_pend;
  assign avl_wdata  = abort_pend ? '0 : fifo_q;

endmodule
